load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage between execute and data_memory. Accepts one load/store/atomic
//  request per transaction, generates and range-checks the effective address, sequences
//  the data_memory control pins (comb read, posedge write), returns a tagged writeback.
//  Atomics (SWAP, FETCH_ADD) are read-modify-write over two memory cycles.
// PARAMETERS
//  DATA_W  19  datapath/word width
//  ADDR_W  4   data_memory address width (16 words)
//  TAG_W   3   destination-register tag width
// PORTS
//  clk           in   1       clock, all state on posedge
//  reset         in   1       asynchronous, active-high; shared with data_memory
//  req_valid     in   1       request present
//  req_ready     out  1       unit can accept (high only in IDLE)
//  req_op        in   2       00 LOAD, 01 STORE, 10 SWAP, 11 FETCH_ADD
//  req_base      in   DATA_W  base register value (unsigned)
//  req_offset    in   4       signed immediate offset (-8..+7)
//  req_wdata     in   DATA_W  store data / swap value / addend
//  req_tag       in   TAG_W   destination tag, returned unchanged
//  dm_addr       out  ADDR_W  to data_memory.addr
//  dm_write_data out  DATA_W  to data_memory.write_data
//  dm_mem_write  out  1       to data_memory.mem_write
//  dm_mem_read   out  1       to data_memory.mem_read
//  dm_read_data  in   DATA_W  from data_memory.read_data (combinational)
//  resp_valid    out  1       response held until accepted
//  resp_ready    in   1       writeback accepts response
//  resp_data     out  DATA_W  load value / old value (atomics) / 0 (store, error)
//  resp_tag      out  TAG_W   tag of completed request
//  resp_err      out  1       effective address out of range; no memory access made
// BEHAVIOUR
//  - Reset (async): state=IDLE; resp_valid/resp_err=0; resp_data/resp_tag/addr/wdata regs=0.
//    All dm_* outputs 0; any in-flight write is dropped (dm_mem_write decoded from state).
//  - Accept on posedge with req_valid&&req_ready; op/tag/wdata/address registered there.
//  - EA = req_base + sext(req_offset), 20-bit signed; error if EA<0 or EA>2^ADDR_W-1.
//  - FSM: IDLE, RD, WR, RESP.
//    LOAD: IDLE->RD->RESP. STORE: IDLE->WR->RESP. SWAP/FETCH_ADD: IDLE->RD->WR->RESP.
//    Error (any op): IDLE->RESP, resp_err=1, resp_data=0, no dm strobe.
//    RESP->IDLE when resp_ready; stays in RESP with all resp_* stable otherwise.
//  - RD: dm_mem_read=1, dm_addr=EA; dm_read_data captured at end of RD into old-value reg.
//  - WR: dm_mem_write=1; dm_write_data = req_wdata (STORE, SWAP) or old+wdata mod 2^DATA_W
//    (FETCH_ADD, carry discarded). Outside RD/WR: dm_mem_read=dm_mem_write=0, data=0.
//  - dm_addr holds registered EA from RD through WR; 0 in IDLE.
//  - Latency accept->resp_valid: LOAD/STORE 2 cycles, atomics 3, error 1.
//  - No new request accepted until RESP handshake completes (req_ready=0 in RD/WR/RESP);
//    req_* may change freely while req_ready=0. One outstanding transaction, no reordering.
//  - Atomicity is by construction: RD and WR are consecutive, unit is sole memory master.
// STRUCTURE
//  - lsu_pkg: DATA_W/ADDR_W/TAG_W defaults, op encodings (OP_LOAD..OP_FADD), state enum.
//  - Sub-module lsu_agu: combinational sign-extend, add, range check -> {ea, err}.
//  - Top holds FSM, request/response registers, dm_* decode; instantiates data_memory
//    only in the bench.
// TESTING  (bench wires unit to data_memory; after reset mem[0]=5, mem[4]=3)
//  - LOAD base=0 off=+4 tag=2 -> dm_mem_read 1 cycle, resp_valid 2 cyc later, data=3, tag=2.
//  - FETCH_ADD base=6 off=-2 wdata=2 -> resp_data=3; mem[4]=5; subsequent LOAD 4 returns 5.
//  - STORE 19'h7FFFF to 7, FETCH_ADD @7 wdata=1 -> resp 19'h7FFFF, mem[7]=0 (wrap).
//  - LOAD base=3 off=-4 and base=15 off=+1 -> resp_err=1, data=0, dm strobes never high.
//  - SWAP @0 wdata=9 with resp_ready=0 for 3 cycles -> resp (5) stable, req_ready=0; mem[0]=9.
//  - Assert reset during WR of STORE @2 wdata=11 -> outputs 0 async, mem[2]=0, state IDLE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: default widths, request
// opcodes and the FSM state encoding.
package lsu_pkg;

    localparam int DATA_W_DEF = 19;
    localparam int ADDR_W_DEF = 4;
    localparam int TAG_W_DEF  = 3;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_FADD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_RESP = 2'b11
    } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of request, response and data_memory signals around the LSU.
//
// Handshake semantics (request and response channels alike): a transfer
// happens on a rising clock edge where valid && ready are both high. The
// response side holds valid and its payload stable until that edge. The
// request side may change valid and payload freely while ready is low.
interface lsu_if #(
    parameter int DATA_W = lsu_pkg::DATA_W_DEF,
    parameter int ADDR_W = lsu_pkg::ADDR_W_DEF,
    parameter int TAG_W  = lsu_pkg::TAG_W_DEF
);
    // request channel
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_base;
    logic [3:0]        req_offset;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;

    // data_memory pins
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_write_data;
    logic              dm_mem_write;
    logic              dm_mem_read;
    logic [DATA_W-1:0] dm_read_data;

    // response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_err;

    // the LSU itself
    modport slave (
        input  req_valid, req_op, req_base, req_offset, req_wdata, req_tag,
        input  resp_ready, dm_read_data,
        output req_ready, resp_valid, resp_data, resp_tag, resp_err,
        output dm_addr, dm_write_data, dm_mem_write, dm_mem_read
    );

    // execute stage / writeback / memory side
    modport master (
        output req_valid, req_op, req_base, req_offset, req_wdata, req_tag,
        output resp_ready, dm_read_data,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_err,
        input  dm_addr, dm_write_data, dm_mem_write, dm_mem_read
    );

endinterface

// File: rtl/load_store_unit_agu.sv
// Address generation: base + sign-extended 4-bit offset, computed one bit
// wider than the datapath so negative results are visible, then checked
// against the data_memory word range.
module lsu_agu #(
    parameter int DATA_W = lsu_pkg::DATA_W_DEF,
    parameter int ADDR_W = lsu_pkg::ADDR_W_DEF
) (
    input  logic [DATA_W-1:0] i_base,
    input  logic [3:0]        i_offset,
    output logic [ADDR_W-1:0] o_ea,
    output logic              o_err
);

    logic [DATA_W:0] w_base_ext;
    logic [DATA_W:0] w_off_ext;
    logic [DATA_W:0] w_sum;

    // Any set bit above the address field means the EA is either negative
    // (top bit set) or past the last memory word.
    always_comb begin
        w_base_ext = {1'b0, i_base};
        w_off_ext  = {{(DATA_W - 3){i_offset[3]}}, i_offset};
        w_sum      = w_base_ext + w_off_ext;
        o_ea       = w_sum[ADDR_W-1:0];
        o_err      = |w_sum[DATA_W:ADDR_W];
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store/atomic request at a time,
// drives data_memory (combinational read, posedge write) and returns a
// tagged writeback. SWAP and FETCH_ADD run as back-to-back RD then WR
// cycles, so they are atomic as long as this unit is the only master.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic   clk,
    input  logic   reset,
    lsu_if.slave   bus,
    output state_e o_dbg_state
);

    logic [ADDR_W-1:0] w_ea;
    logic              w_err;

    state_e            r_state;
    op_e               r_op;
    logic [ADDR_W-1:0] r_ea;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_old;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_resp_data;
    logic [TAG_W-1:0]  r_resp_tag;

    logic [DATA_W-1:0] w_fadd_sum;
    logic [ADDR_W-1:0] w_dm_addr;
    logic [DATA_W-1:0] w_dm_wdata;
    logic              w_dm_read;
    logic              w_dm_write;

    lsu_agu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_agu (
        .i_base   (bus.req_base),
        .i_offset (bus.req_offset),
        .o_ea     (w_ea),
        .o_err    (w_err)
    );

    // Transaction FSM; request fields and the response are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= OP_LOAD;
            r_ea         <= '0;
            r_wdata      <= '0;
            r_old        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op       <= op_e'(bus.req_op);
                        r_ea       <= w_ea;
                        r_wdata    <= bus.req_wdata;
                        r_resp_tag <= bus.req_tag;
                        if (w_err) begin
                            // bad address: answer immediately, never touch memory
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                        end else if (op_e'(bus.req_op) == OP_STORE) begin
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_old <= bus.dm_read_data;
                    if (r_op == OP_LOAD) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= bus.dm_read_data;
                    end else begin
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    // atomics return the pre-write value, stores return zero
                    r_resp_data  <= (r_op == OP_STORE) ? '0 : r_old;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory strobes are decoded from state so an async reset drops a
    // pending write on the spot.
    always_comb begin
        w_fadd_sum = r_old + r_wdata;
        w_dm_addr  = '0;
        w_dm_wdata = '0;
        w_dm_read  = 1'b0;
        w_dm_write = 1'b0;
        case (r_state)
            S_RD: begin
                w_dm_read = 1'b1;
                w_dm_addr = r_ea;
            end
            S_WR: begin
                w_dm_write = 1'b1;
                w_dm_addr  = r_ea;
                w_dm_wdata = (r_op == OP_FADD) ? w_fadd_sum : r_wdata;
            end
            default: ;
        endcase
    end

    assign bus.req_ready     = (r_state == S_IDLE);
    assign bus.dm_addr       = w_dm_addr;
    assign bus.dm_write_data = w_dm_wdata;
    assign bus.dm_mem_read   = w_dm_read;
    assign bus.dm_mem_write  = w_dm_write;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_err      = r_resp_err;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_tag      = r_resp_tag;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: wires the unit to a behavioural data_memory,
// runs a directed vector table, hand-written stall and reset sequences,
// then randomized transactions checked against a word-level memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DW = 19;
    localparam int AW = 4;
    localparam int TW = 3;

    logic   clk;
    logic   reset;
    state_e dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    lsu_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) bus ();

    load_store_unit #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data_memory model ----------------
    logic [DW-1:0] mem [16];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0] <= 19'd5;
            mem[4] <= 19'd3;
        end else if (bus.dm_mem_write) begin
            mem[bus.dm_addr] <= bus.dm_write_data;
        end
    end

    assign bus.dm_read_data = mem[bus.dm_addr];

    // ---------------- reference model ----------------
    logic [DW-1:0] model_mem [16];

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        model_mem[0] = 19'd5;
        model_mem[4] = 19'd3;
    endfunction

    function automatic void model_txn(input logic [1:0] op, input logic [DW-1:0] base,
                                      input logic [3:0] off, input logic [DW-1:0] wdata,
                                      output logic [DW-1:0] e_data, output logic e_err,
                                      output int e_lat, output int e_rd, output int e_wr);
        int ea;
        int old;
        ea = int'(base) + int'($signed(off));
        e_data = '0; e_err = 1'b0; e_lat = 0; e_rd = 0; e_wr = 0;
        if (ea < 0 || ea > 15) begin
            e_err = 1'b1;
            e_lat = 1;
            return;
        end
        old = int'(model_mem[ea]);
        case (op)
            2'd0: begin e_data = DW'(old); e_lat = 2; e_rd = 1; end
            2'd1: begin model_mem[ea] = wdata; e_lat = 2; e_wr = 1; end
            2'd2: begin e_data = DW'(old); model_mem[ea] = wdata; e_lat = 3; e_rd = 1; e_wr = 1; end
            default: begin
                e_data = DW'(old);
                model_mem[ea] = DW'((old + int'(wdata)) % (1 << DW));
                e_lat = 3; e_rd = 1; e_wr = 1;
            end
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_mem_all();
        for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(model_mem[i]));
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input logic [1:0] op, input logic [DW-1:0] base, input logic [3:0] off,
                           input logic [DW-1:0] wdata, input logic [TW-1:0] tag, input int stall,
                           input logic [DW-1:0] exp_data, input logic exp_err, input logic [TW-1:0] exp_tag,
                           output logic [DW-1:0] got_data, output logic got_err,
                           output logic [TW-1:0] got_tag, output int lat,
                           output int rd_n, output int wr_n);
        int g;
        lat = 0; rd_n = 0; wr_n = 0;
        got_data = '0; got_err = 1'b0; got_tag = '0;
        @(negedge clk);
        g = 0;
        while (!bus.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wdata;
        bus.req_tag    = tag;
        @(posedge clk);
        #1;
        // request pins are don't-care while the unit is busy
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_op     = 2'($urandom);
        bus.req_base   = DW'($urandom);
        bus.req_offset = 4'($urandom);
        bus.req_wdata  = DW'($urandom);
        bus.req_tag    = TW'($urandom);
        do begin
            @(negedge clk);
            lat++;
            rd_n += int'(bus.dm_mem_read);
            wr_n += int'(bus.dm_mem_write);
        end while (!bus.resp_valid && lat < 10);
        if (!bus.resp_valid) begin
            check("resp_valid_timeout", 32'(bus.resp_valid), 32'd1);
        end
        got_data = bus.resp_data;
        got_err  = bus.resp_err;
        got_tag  = bus.resp_tag;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            rd_n += int'(bus.dm_mem_read);
            wr_n += int'(bus.dm_mem_write);
            check("stall_valid", 32'(bus.resp_valid), 32'd1);
            check("stall_data", 32'(bus.resp_data), 32'(exp_data));
            check("stall_err", 32'(bus.resp_err), 32'(exp_err));
            check("stall_tag", 32'(bus.resp_tag), 32'(exp_tag));
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] base;
        logic [3:0]    off;
        logic [DW-1:0] wdata;
        logic [TW-1:0] tag;
        int            stall;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            exp_lat;
        int            exp_rd;
        int            exp_wr;
        int            mem_addr;
        logic [DW-1:0] exp_mem;
    } vec_t;

    vec_t tbl [12];

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] got_data, e_data;
        logic          got_err, e_err;
        logic [TW-1:0] got_tag;
        int            lat, rd_n, wr_n, e_lat, e_rd, e_wr;
        logic [1:0]    r_op;
        logic [DW-1:0] r_base, r_wdata;
        logic [3:0]    r_off;
        logic [TW-1:0] r_tag;
        int            r_stall;

        //          op     base        off    wdata        tag   st  data         err lat rd wr addr mem
        tbl[0]  = '{2'd0, 19'd0,      4'h4, 19'd0,       3'd2, 0, 19'd3,       1'b0, 2, 1, 0, 4,  19'd3};
        tbl[1]  = '{2'd3, 19'd6,      4'hE, 19'd2,       3'd1, 0, 19'd3,       1'b0, 3, 1, 1, 4,  19'd5};
        tbl[2]  = '{2'd0, 19'd4,      4'h0, 19'd0,       3'd3, 0, 19'd5,       1'b0, 2, 1, 0, 4,  19'd5};
        tbl[3]  = '{2'd1, 19'd7,      4'h0, 19'h7FFFF,   3'd4, 0, 19'd0,       1'b0, 2, 0, 1, 7,  19'h7FFFF};
        tbl[4]  = '{2'd3, 19'd7,      4'h0, 19'd1,       3'd5, 0, 19'h7FFFF,   1'b0, 3, 1, 1, 7,  19'd0};
        tbl[5]  = '{2'd0, 19'd3,      4'hC, 19'd0,       3'd6, 0, 19'd0,       1'b1, 1, 0, 0, -1, 19'd0};
        tbl[6]  = '{2'd0, 19'd15,     4'h1, 19'd0,       3'd7, 0, 19'd0,       1'b1, 1, 0, 0, -1, 19'd0};
        tbl[7]  = '{2'd0, 19'h7FFFF,  4'h7, 19'd0,       3'd0, 0, 19'd0,       1'b1, 1, 0, 0, -1, 19'd0};
        tbl[8]  = '{2'd2, 19'd0,      4'h0, 19'd9,       3'd7, 3, 19'd5,       1'b0, 3, 1, 1, 0,  19'd9};
        tbl[9]  = '{2'd0, 19'd8,      4'h8, 19'd0,       3'd1, 1, 19'd9,       1'b0, 2, 1, 0, 0,  19'd9};
        tbl[10] = '{2'd0, 19'd15,     4'h0, 19'd0,       3'd2, 0, 19'd0,       1'b0, 2, 1, 0, 15, 19'd0};
        tbl[11] = '{2'd2, 19'd20,     4'hB, 19'd123,     3'd3, 2, 19'd0,       1'b0, 3, 1, 1, 15, 19'd123};

        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_base   = '0;
        bus.req_offset = '0;
        bus.req_wdata  = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        // reset state while reset is held
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_data", 32'(bus.resp_data), 32'd0);
        check("rst_dm_strobes", {30'd0, bus.dm_mem_read, bus.dm_mem_write}, 32'd0);
        check("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // directed table
        for (int v = 0; v < 12; v++) begin
            run_txn(tbl[v].op, tbl[v].base, tbl[v].off, tbl[v].wdata, tbl[v].tag, tbl[v].stall,
                    tbl[v].exp_data, tbl[v].exp_err, tbl[v].tag,
                    got_data, got_err, got_tag, lat, rd_n, wr_n);
            model_txn(tbl[v].op, tbl[v].base, tbl[v].off, tbl[v].wdata, e_data, e_err, e_lat, e_rd, e_wr);
            check($sformatf("v%0d_data", v), 32'(got_data), 32'(tbl[v].exp_data));
            check($sformatf("v%0d_err", v), 32'(got_err), 32'(tbl[v].exp_err));
            check($sformatf("v%0d_tag", v), 32'(got_tag), 32'(tbl[v].tag));
            check($sformatf("v%0d_lat", v), 32'(lat), 32'(tbl[v].exp_lat));
            check($sformatf("v%0d_rd", v), 32'(rd_n), 32'(tbl[v].exp_rd));
            check($sformatf("v%0d_wr", v), 32'(wr_n), 32'(tbl[v].exp_wr));
            if (tbl[v].mem_addr >= 0)
                check($sformatf("v%0d_mem", v), 32'(mem[tbl[v].mem_addr]), 32'(tbl[v].exp_mem));
        end
        check_mem_all();

        // reset asserted during the WR cycle of a STORE @2
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = 2'd1;
        bus.req_base   = 19'd2;
        bus.req_offset = 4'h0;
        bus.req_wdata  = 19'd11;
        bus.req_tag    = 3'd6;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("wr_state", 32'(dbg_state), 32'(S_WR));
        check("wr_strobe", 32'(bus.dm_mem_write), 32'd1);
        check("wr_addr", 32'(bus.dm_addr), 32'd2);
        reset = 1'b1;
        #1;
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        check("arst_write", 32'(bus.dm_mem_write), 32'd0);
        check("arst_read", 32'(bus.dm_mem_read), 32'd0);
        check("arst_addr", 32'(bus.dm_addr), 32'd0);
        check("arst_wdata", 32'(bus.dm_write_data), 32'd0);
        check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("arst_resp_tag", 32'(bus.resp_tag), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("arst_mem2", 32'(mem[2]), 32'd0);
        check("arst_req_ready", 32'(bus.req_ready), 32'd1);
        run_txn(2'd0, 19'd2, 4'h0, 19'd0, 3'd5, 0, 19'd0, 1'b0, 3'd5,
                got_data, got_err, got_tag, lat, rd_n, wr_n);
        check("post_rst_load2", 32'(got_data), 32'd0);
        check("post_rst_tag", 32'(got_tag), 32'd5);

        // randomized transactions against the model
        for (int n = 0; n < 60; n++) begin
            r_op    = 2'($urandom);
            r_base  = ($urandom_range(0, 9) < 8) ? DW'($urandom_range(0, 22)) : DW'($urandom);
            r_off   = 4'($urandom);
            r_wdata = ($urandom_range(0, 3) == 0) ? DW'(19'h7FFFF - $urandom_range(0, 3)) : DW'($urandom);
            r_tag   = TW'($urandom);
            r_stall = $urandom_range(0, 2);
            model_txn(r_op, r_base, r_off, r_wdata, e_data, e_err, e_lat, e_rd, e_wr);
            run_txn(r_op, r_base, r_off, r_wdata, r_tag, r_stall, e_data, e_err, r_tag,
                    got_data, got_err, got_tag, lat, rd_n, wr_n);
            check($sformatf("r%0d_data", n), 32'(got_data), 32'(e_data));
            check($sformatf("r%0d_err", n), 32'(got_err), 32'(e_err));
            check($sformatf("r%0d_tag", n), 32'(got_tag), 32'(r_tag));
            check($sformatf("r%0d_lat", n), 32'(lat), 32'(e_lat));
            check($sformatf("r%0d_rd", n), 32'(rd_n), 32'(e_rd));
            check($sformatf("r%0d_wr", n), 32'(wr_n), 32'(e_wr));
        end
        check_mem_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

endmodule
